// File: rtl/regfile_fifo_ctrl.sv
`timescale 1ns/1ps
// Pointer and handshake controller that wraps the 32x4 register-file BEL into a
// first-word-fall-through FIFO with valid/ready streams on both sides.
module regfile_fifo_ctrl #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int RD_REG   = 0,
  parameter int AFULL_TH = 28
) (
  input  logic              UserCLK,
  input  logic              UserRSTn,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] rf_D,
  output logic [ADDR_W-1:0] rf_W_ADR,
  output logic              rf_W_en,
  output logic [ADDR_W-1:0] rf_A_ADR,
  input  logic [DATA_W-1:0] rf_AD,
  output logic [ADDR_W:0]   level,
  output logic              almost_full
);

  localparam int            PW       = ADDR_W + 1;
  localparam logic [PW-1:0] AFULL_LV = PW'(AFULL_TH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_level;
  logic          r_almost_full;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_out_valid;
  logic [PW-1:0] w_rd_ptr_inc;
  logic [PW-1:0] w_level_less_pop;
  logic [PW-1:0] w_level_next;

  // Full when the pointers differ only in the wrap bit; no pass-through on pop.
  assign w_full = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                  (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign in_ready = !w_full;

  assign w_push           = in_valid && !w_full && !flush && UserRSTn;
  assign w_pop            = w_out_valid && out_ready;
  assign w_rd_ptr_inc     = r_rd_ptr + PW'(1);
  assign w_level_less_pop = r_level - PW'(w_pop);
  assign w_level_next     = w_level_less_pop + PW'(w_push);

  assign rf_D        = in_data;
  assign rf_W_ADR    = r_wr_ptr[ADDR_W-1:0];
  assign rf_W_en     = w_push;
  assign out_data    = rf_AD;
  assign out_valid   = w_out_valid;
  assign level       = r_level;
  assign almost_full = r_almost_full;

  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_almost_full <= 1'b0;
    end else if (flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= w_rd_ptr_inc;
      r_level       <= w_level_next;
      r_almost_full <= (w_level_next >= AFULL_LV);
    end
  end

  // RD_REG must match the register file's AD_reg configuration bit.
  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic r_out_valid;

      // Only entries written at earlier edges count: a word written at the edge
      // its address is captured reads stale, so that read repeats next cycle.
      always_ff @(posedge UserCLK or negedge UserRSTn) begin
        if (!UserRSTn)
          r_out_valid <= 1'b0;
        else if (flush)
          r_out_valid <= 1'b0;
        else
          r_out_valid <= (w_level_less_pop != '0);
      end

      assign w_out_valid = r_out_valid;
      assign rf_A_ADR    = w_pop ? w_rd_ptr_inc[ADDR_W-1:0] : r_rd_ptr[ADDR_W-1:0];
    end else begin : g_rd_comb
      assign w_out_valid = (r_level != '0);
      assign rf_A_ADR    = r_rd_ptr[ADDR_W-1:0];
    end
  endgenerate

endmodule

// File: doc/regfile_fifo_ctrl.md
Name: regfile_fifo_ctrl

Overview:
- Pointer and handshake controller that sits directly upstream and downstream of the 32x4 register-file BEL and turns it into a 32-entry, 4-bit first-word-fall-through FIFO.
- Drives the register file's write port (D, W_ADR, W_en) and read port A address (A_ADR), and consumes its AD read data.
- Presents valid/ready streams on both the producer and consumer sides.
- RD_REG must match the register file's AD_reg configuration bit (ConfigBits[0]).

Parameters:
- DATA_W, 4, word width; equals the register file data width.
- ADDR_W, 5, address width; depth is 2**ADDR_W = 32.
- RD_REG, 0, 0 = register file port A combinational; 1 = port A registered.
- AFULL_TH, 28, level at or above which almost_full asserts (range 1..32).

Ports:
- UserCLK  input  1  fabric user clock; shared with the register file.
- UserRSTn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of FIFO state.
- in_valid  input  1  producer word valid.
- in_data  input  DATA_W  producer word.
- in_ready  output  1  FIFO can accept a word.
- out_valid  output  1  head word valid on out_data.
- out_data  output  DATA_W  head word.
- out_ready  input  1  consumer accepts head word.
- rf_D  output  DATA_W  to register file D.
- rf_W_ADR  output  ADDR_W  to register file W_ADR.
- rf_W_en  output  1  to register file W_en.
- rf_A_ADR  output  ADDR_W  to register file A_ADR.
- rf_AD  input  DATA_W  from register file AD.
- level  output  ADDR_W+1  number of stored entries, 0..32.
- almost_full  output  1  level >= AFULL_TH.

Behaviour:
- State:
  - wr_ptr and rd_ptr: ADDR_W+1 bits each, with the MSB used as a wrap bit.
  - level register.
  - out_valid register, RD_REG=1 only.
- Reset (UserRSTn low, asynchronous): wr_ptr=0, rd_ptr=0, level=0, out_valid=0, in_ready=1, almost_full=0, rf_W_en=0. Register file contents are not cleared; they are unobservable while empty.
- Status flags:
  - full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (low bits equal).
  - in_ready = !full. There is no pass-through: in_ready stays low when full even if a pop occurs in the same cycle.
- Push = in_valid && in_ready. On a push:
  - rf_W_en=1, rf_W_ADR=wr_ptr[ADDR_W-1:0], rf_D=in_data (combinational).
  - wr_ptr increments at the clock edge and wraps modulo 64.
- Pop = out_valid && out_ready. On a pop, rd_ptr increments at the edge and wraps modulo 64.
- level_next = level + push - pop. Simultaneous push and pop leaves level unchanged.
- RD_REG=0:
  - rf_A_ADR = rd_ptr[ADDR_W-1:0].
  - out_valid = (level != 0), combinational from the registered level.
  - out_data = rf_AD.
  - Push-to-out_valid latency when empty: 1 cycle.
- RD_REG=1:
  - rf_A_ADR = (pop ? rd_ptr+1 : rd_ptr)[ADDR_W-1:0]. This presents the next head so the register file's output register captures it at the edge.
  - out_valid <= ((level - pop) != 0). This counts only entries written at earlier edges.
  - A word written at the same edge that its address is captured is stale. out_valid stays 0 for that cycle and the read is repeated the following cycle.
  - out_data = rf_AD.
  - Push-to-out_valid latency when empty: 2 cycles.
  - Back-to-back pops sustain 1 word per cycle while level >= 2.
- Stall: out_valid && !out_ready holds rd_ptr, rf_A_ADR and out_data stable.
- Flush (synchronous): has priority over push and pop in the same cycle. Sets pointers, level and out_valid to 0. rf_W_en is forced to 0 during the flush cycle.
- almost_full is registered alongside level (level_next >= AFULL_TH).
- Reset asserted mid-transfer discards all content. The first push after release is stored at address 0.

Test Plan:
- RD_REG=0: push 0x1..0xF then 0x0 repeating, 32 words, out_ready=0.
  - in_ready drops after the 32nd push; level=32; almost_full set from level 28.
  - A 33rd in_valid is not written (rf_W_en=0).
- RD_REG=0, full FIFO: pop all 32 words with out_ready=1 every cycle.
  - Data appear in push order.
  - out_valid falls when level reaches 0; rd_ptr wraps to 0x20.
- RD_REG=1, empty FIFO: single push of 0xA at cycle 0.
  - out_valid=0 in cycle 1.
  - out_valid=1 with out_data=0xA in cycle 2.
- RD_REG=1: continuous push and pop at 1 word/cycle for 100 cycles, crossing the pointer wrap twice.
  - No drops, no duplicates.
  - level is constant after fill.
  - out_data sequence equals the input sequence.
- Stall then flush:
  - Hold out_ready=0 with level=5 for 3 cycles: out_data is stable.
  - Assert flush coincident with in_valid=1: level=0 and out_valid=0 next cycle; the pushed word is dropped.
- Reset mid-operation: assert UserRSTn=0 asynchronously with level=12.
  - Outputs clear immediately: out_valid=0, level=0, in_ready=1.
  - First post-reset push drives rf_W_ADR=0.
